// File: rtl/odd_even_sequencer_pkg.sv
// Shared types and constants for the odd/even parity path.
package odd_even_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    localparam logic PAR_EVEN = 1'b1;
    localparam logic PAR_ODD  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A number is even exactly when its least significant bit is clear.
    function automatic logic lsb_is_even(input logic lsb);
        return ~lsb;
    endfunction

endpackage

// File: rtl/odd_even_sequencer_checker.sv
// Parity classifier; also guards that checked numbers carry the expected parity.
module odd_even_checker
    import odd_even_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_lsb,
    input  logic i_check_en,
    input  logic i_expect_even,
    output logic o_is_even
);

    assign o_is_even = lsb_is_even(i_lsb);

    a_parity_match: assert property (@(posedge i_clk) disable iff (i_reset)
        i_check_en |-> (o_is_even == i_expect_even));

endmodule

// File: rtl/odd_even_sequencer.sv
// Programmable even/odd number generator with a valid/ready output stream.
module odd_even_sequencer
    import odd_even_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_want_even,
    input  logic [WIDTH-1:0] i_seed,
    input  logic [CNT_W-1:0] i_count,
    output logic             o_busy,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_number,
    output logic             o_out_last,
    output logic             o_done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] w_value_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_remaining_nxt;
    logic             r_want_even;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_done;
    logic             r_busy;
    logic             w_valid_nxt;
    logic             w_last_nxt;
    logic             w_done_nxt;
    logic             w_busy_nxt;
    logic             w_accept;
    logic             w_count_zero;
    logic             w_handshake;
    logic             w_is_last;
    logic             w_chk_lsb;
    logic             w_is_even;
    logic             w_align;

    assign w_accept     = (r_state == ST_IDLE) && i_start;
    assign w_count_zero = (i_count == {CNT_W{1'b0}});
    assign w_handshake  = r_out_valid && i_out_ready;
    assign w_is_last    = (r_remaining == CNT_W'(1));
    assign w_align      = w_is_even ^ i_want_even;

    // While idle the checker classifies the seed; while running it watches the output.
    assign w_chk_lsb = (r_state == ST_IDLE) ? i_seed[0] : r_value[0];

    odd_even_checker u_checker (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_lsb         (w_chk_lsb),
        .i_check_en    (r_out_valid),
        .i_expect_even (r_want_even),
        .o_is_even     (w_is_even)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = w_count_zero ? ST_DONE : ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_handshake && w_is_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Value and item-count updates; parity is preserved because steps are always 2.
    always_comb begin
        w_value_nxt     = r_value;
        w_remaining_nxt = r_remaining;
        if (w_accept && !w_count_zero) begin
            w_value_nxt     = i_seed + {{(WIDTH-1){1'b0}}, w_align};
            w_remaining_nxt = i_count;
        end else if (w_handshake && (r_remaining != {CNT_W{1'b0}})) begin
            w_value_nxt     = r_value + WIDTH'(2);
            w_remaining_nxt = r_remaining - CNT_W'(1);
        end else begin
            w_value_nxt     = r_value;
            w_remaining_nxt = r_remaining;
        end
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        w_valid_nxt = (w_state_nxt == ST_RUN);
        w_busy_nxt  = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DONE);
        w_done_nxt  = (w_state_nxt == ST_DONE);
        w_last_nxt  = (w_state_nxt == ST_RUN) && (w_remaining_nxt == CNT_W'(1));
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_value     <= {WIDTH{1'b0}};
            r_remaining <= {CNT_W{1'b0}};
            r_want_even <= PAR_EVEN;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_value     <= w_value_nxt;
            r_remaining <= w_remaining_nxt;
            r_want_even <= w_accept ? i_want_even : r_want_even;
            r_out_valid <= w_valid_nxt;
            r_out_last  <= w_last_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign o_busy       = r_busy;
    assign o_out_valid  = r_out_valid;
    assign o_out_last   = r_out_last;
    assign o_out_number = r_value;
    assign o_done       = r_done;

endmodule

// File: tb/tb_odd_even_sequencer.sv
// Table-driven bench with a scoreboard queue for odd_even_sequencer.
module tb_odd_even_sequencer;
    import odd_even_pkg::*;

    typedef struct {
        logic       want;
        logic [7:0] seed;
        logic [7:0] count;
        logic [7:0] first;
    } vec_t;

    typedef struct {
        logic [7:0] num;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       want_even = 1'b0;
    logic [7:0] seed = 8'd0;
    logic [7:0] count = 8'd0;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       out_valid;
    logic [7:0] out_number;
    logic       out_last;
    logic       done;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    vec_t tbl[9];

    odd_even_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_want_even  (want_even),
        .i_seed       (seed),
        .i_count      (count),
        .o_busy       (busy),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_number (out_number),
        .o_out_last   (out_last),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: an item is consumed at the next rising edge when valid and ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_item", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("item_number", {24'd0, out_number}, {24'd0, mon_e.num});
                check("item_last", {31'd0, out_last}, {31'd0, mon_e.last});
            end
        end
    end

    task automatic launch(input logic we, input logic [7:0] sd, input logic [7:0] cnt,
                          input logic [7:0] first);
        want_even = we;
        seed      = sd;
        count     = cnt;
        start     = 1'b1;
        for (int k = 0; k < int'(cnt); k++) begin
            exp_t e;
            e.num  = first + 8'(2 * k);
            e.last = (k == int'(cnt) - 1);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start     = 1'b0;
        want_even = ~we;
        seed      = 8'hA5;
        count     = 8'd7;
    endtask

    task automatic wait_done(input int exp_lat);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk);
            lat++;
            if (k == 0) check("busy_after_start", {31'd0, busy}, 32'd1);
            if (done) seen = 1'b1;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        if (exp_lat >= 0) check("latency", lat, exp_lat);
        check("done_valid_low", {31'd0, out_valid}, 32'd0);
        check("done_busy_high", {31'd0, busy}, 32'd1);
        check("sb_empty", sb_q.size(), 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_busy_low", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'd6,   8'd3, 8'd6};
        tbl[1] = '{1'b0, 8'd6,   8'd2, 8'd7};
        tbl[2] = '{1'b1, 8'd11,  8'd1, 8'd12};
        tbl[3] = '{1'b1, 8'd253, 8'd3, 8'd254};
        tbl[4] = '{1'b0, 8'd255, 8'd2, 8'd255};
        tbl[5] = '{1'b1, 8'd9,   8'd0, 8'd0};
        tbl[6] = '{1'b0, 8'd0,   8'd4, 8'd1};
        tbl[7] = '{1'b1, 8'd255, 8'd2, 8'd0};
        tbl[8] = '{1'b0, 8'd128, 8'd1, 8'd129};

        #2 rst = 1'b1;
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_number", {24'd0, out_number}, 32'd0);
        check("rst_last", {31'd0, out_last}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            launch(tbl[i].want, tbl[i].seed, tbl[i].count, tbl[i].first);
            wait_done(int'(tbl[i].count) + 1);
        end

        // Backpressure while 8 is presented.
        launch(PAR_EVEN, 8'd6, 8'd3, 8'd6);
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_number", {24'd0, out_number}, 32'd8);
            check("bp_hold_last", {31'd0, out_last}, 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done(-1);

        // Start pulse during RUN must be ignored.
        launch(PAR_EVEN, 8'd20, 8'd4, 8'd20);
        @(posedge clk);
        #1;
        start     = 1'b1;
        want_even = PAR_ODD;
        seed      = 8'd99;
        count     = 8'd7;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(-1);

        // Reset mid-sequence after the first handshake.
        launch(PAR_EVEN, 8'd0, 8'd5, 8'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_number", {24'd0, out_number}, 32'd0);
        check("mid_rst_last", {31'd0, out_last}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        sb_q.delete();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("mid_rst_no_done", {31'd0, done}, 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_no_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        launch(PAR_ODD, 8'd3, 8'd2, 8'd3);
        wait_done(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
